// File: rtl/axi_lite_slave_buffered.sv
// Registered AXI4-Lite slave bridging to a GP write/read request interface.
// Optional macro AXIL_TIMEOUT_EN adds a per-channel timeout that aborts a hung GP request.
module axi_lite_slave_buffered #(
  parameter int GP_ADDR_WIDTH      = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  output logic                            write,
  output logic [GP_ADDR_WIDTH-1:0]        write_addrs,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   write_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] write_strobe,
  input  logic                            write_done,
  input  logic                            write_error,
  output logic                            read,
  output logic [GP_ADDR_WIDTH-1:0]        read_addrs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   read_data,
  input  logic                            read_done,
  input  logic                            read_error,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int GW = GP_ADDR_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rstate_t;

  wstate_t         wstate_q, wstate_d;
  rstate_t         rstate_q, rstate_d;
  logic            aw_got_q, aw_got_d, w_got_q, w_got_d, aw_oor_q, aw_oor_d;
  logic [GW-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            write_q, write_d, read_q, read_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
  logic            aw_hs, w_hs, ar_hs, wr_oor;
`ifdef AXIL_TIMEOUT_EN
  logic [CW-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif
  logic            unused_inputs;

  // Any AXI address bit at or above the GP address width makes the access illegal.
  function automatic logic out_of_range(input logic [AW-1:0] a);
    return (a >> GW) != '0;
  endfunction

  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, TIMEOUT_CYCLES > 1};

  assign s_axi_awready = (wstate_q == W_IDLE) && !aw_got_q;
  assign s_axi_wready  = (wstate_q == W_IDLE) && !w_got_q;
  assign s_axi_arready = (rstate_q == R_IDLE);
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign wr_oor = aw_hs ? out_of_range(s_axi_awaddr) : aw_oor_q;

  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    aw_oor_d = aw_oor_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    write_d  = write_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
`ifdef AXIL_TIMEOUT_EN
    wcnt_d   = wcnt_q;
`endif
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = s_axi_awaddr[GW-1:0];
          aw_oor_d = out_of_range(s_axi_awaddr);
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
        end
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          if (wr_oor) begin
            wstate_d = W_RESP;
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
          end else begin
            wstate_d = W_REQ;
            write_d  = 1'b1;
`ifdef AXIL_TIMEOUT_EN
            wcnt_d   = '0;
`endif
          end
        end
      end
      W_REQ: begin
        if (write_done) begin
          wstate_d = W_RESP;
          write_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = write_error ? RESP_SLVERR : RESP_OKAY;
        end
`ifdef AXIL_TIMEOUT_EN
        else if (wcnt_q == CNT_LAST) begin
          wstate_d = W_RESP;
          write_d  = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
`endif
      end
      W_RESP: begin
        if (s_axi_bready) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    read_d   = read_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
`ifdef AXIL_TIMEOUT_EN
    rcnt_d   = rcnt_q;
`endif
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d = s_axi_araddr[GW-1:0];
          if (out_of_range(s_axi_araddr)) begin
            rstate_d = R_RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
          end else begin
            rstate_d = R_REQ;
            read_d   = 1'b1;
`ifdef AXIL_TIMEOUT_EN
            rcnt_d   = '0;
`endif
          end
        end
      end
      R_REQ: begin
        if (read_done) begin
          rstate_d = R_RESP;
          read_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = read_data;
          rresp_d  = read_error ? RESP_SLVERR : RESP_OKAY;
        end
`ifdef AXIL_TIMEOUT_EN
        else if (rcnt_q == CNT_LAST) begin
          rstate_d = R_RESP;
          read_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
`endif
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Data registers are cleared too so the GP side never sees stale values after reset.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_oor_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      write_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      raddr_q  <= '0;
      rdata_q  <= '0;
      read_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
`ifdef AXIL_TIMEOUT_EN
      wcnt_q   <= '0;
      rcnt_q   <= '0;
`endif
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      aw_oor_q <= aw_oor_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      write_q  <= write_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      read_q   <= read_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
`ifdef AXIL_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  assign write        = write_q;
  assign write_addrs  = waddr_q;
  assign write_data   = wdata_q;
  assign write_strobe = wstrb_q;
  assign read         = read_q;
  assign read_addrs   = raddr_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_buffered.sv
// Self-checking bench for axi_lite_slave_buffered: directed AXI-Lite transactions plus a
// randomized mix checked against a register-file model; timeout cases under AXIL_TIMEOUT_EN.
module tb_axi_lite_slave_buffered;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, read, write_done, write_error, read_done, read_error;
  logic [5:0]  write_addrs, read_addrs;
  logic [31:0] write_data, read_data, s_axi_wdata, s_axi_rdata;
  logic [3:0]  write_strobe, s_axi_wstrb;
  logic [7:0]  s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;

  int vec = 0;
  int miss = 0;

  // GP responder knobs: done after N request cycles (0 = never), error flag
  int gp_wdelay = 1, gp_rdelay = 1;
  bit gp_werr = 0, gp_rerr = 0;
  logic [31:0] gp_mem [64];
  logic [31:0] ref_mem [64];

  axi_lite_slave_buffered #(
    .GP_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .write(write), .write_addrs(write_addrs), .write_data(write_data),
    .write_strobe(write_strobe), .write_done(write_done), .write_error(write_error),
    .read(read), .read_addrs(read_addrs), .read_data(read_data),
    .read_done(read_done), .read_error(read_error),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // GP-side slave: answers requests at the falling edge after the configured number of cycles.
  initial begin
    int wc, rc;
    wc = 0; rc = 0;
    write_done = 0; write_error = 0; read_done = 0; read_error = 0; read_data = '0;
    forever begin
      @(negedge clk);
      write_done = 0; write_error = 0; read_done = 0; read_error = 0;
      read_data = $urandom;
      if (write === 1'b1) begin
        wc++;
        if (wc == gp_wdelay) begin
          write_done = 1; write_error = gp_werr;
          if (!gp_werr) gp_mem[write_addrs] = merge(gp_mem[write_addrs], write_data, write_strobe);
        end
      end else wc = 0;
      if (read === 1'b1) begin
        rc++;
        if (rc == gp_rdelay) begin
          read_done = 1; read_error = gp_rerr; read_data = gp_mem[read_addrs];
        end
      end else rc = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_req = cycles write must stay high (0: illegal address, no GP write)
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_at, input int w_at, input int bwait,
                          input logic [1:0] exp_b, input int exp_req);
    bit awd, wd, aw_hs, w_hs;
    int c, n;
    awd = 0; wd = 0; c = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(awd && wd) && c < 20) begin
      s_axi_awvalid = !awd && (c >= aw_at);
      s_axi_wvalid  = !wd && (c >= w_at);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      if (awd) check("awready_after_hs", s_axi_awready, 0);
      if (wd)  check("wready_after_hs", s_axi_wready, 0);
      step();
      if (aw_hs) awd = 1;
      if (w_hs) wd = 1;
      c++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("w_handshakes", {awd, wd}, 2'b11);
    n = 0;
    if (exp_req == 0) begin
      check("w_oor_no_write", write, 0);
    end else begin
      while (s_axi_bvalid !== 1'b1 && n < 300) begin
        check("write_req", write, 1);
        check("write_addrs", write_addrs, addr[5:0]);
        check("write_data", write_data, data);
        check("write_strobe", write_strobe, strb);
        n++;
        step();
      end
    end
    check("write_req_cycles", n, exp_req);
    check("write_dropped", write, 0);
    check("bvalid", s_axi_bvalid, 1);
    check("bresp", s_axi_bresp, exp_b);
    for (int i = 0; i < bwait; i++) begin
      check("awready_busy", {s_axi_awready, s_axi_wready}, 2'b00);
      step();
      check("bvalid_held", s_axi_bvalid, 1);
      check("bresp_held", s_axi_bresp, exp_b);
    end
    s_axi_bready = 1;
    step();
    s_axi_bready = 0;
    check("bvalid_clear", s_axi_bvalid, 0);
    check("w_ready_back", {s_axi_awready, s_axi_wready}, 2'b11);
  endtask

  task automatic do_read(input logic [7:0] addr, input int rwait, input logic [1:0] exp_r,
                         input logic [31:0] exp_d, input int exp_req);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1;
    check("arready_idle", s_axi_arready, 1);
    step();
    s_axi_arvalid = 0;
    n = 0;
    if (exp_req == 0) begin
      check("r_oor_no_read", read, 0);
    end else begin
      while (s_axi_rvalid !== 1'b1 && n < 300) begin
        check("read_req", read, 1);
        check("read_addrs", read_addrs, addr[5:0]);
        n++;
        step();
      end
    end
    check("read_req_cycles", n, exp_req);
    check("read_dropped", read, 0);
    check("rvalid", s_axi_rvalid, 1);
    check("rresp", s_axi_rresp, exp_r);
    check("rdata", s_axi_rdata, exp_d);
    for (int i = 0; i < rwait; i++) begin
      check("arready_busy", s_axi_arready, 0);
      step();
      check("rvalid_held", s_axi_rvalid, 1);
      check("rdata_held", s_axi_rdata, exp_d);
      check("rresp_held", s_axi_rresp, exp_r);
    end
    s_axi_rready = 1;
    step();
    s_axi_rready = 0;
    check("rvalid_clear", s_axi_rvalid, 0);
    check("arready_back", s_axi_arready, 1);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          oor;
    int          n;
    for (int i = 0; i < 64; i++) begin gp_mem[i] = '0; ref_mem[i] = '0; end
    rst = 1;
    s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0;
    s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = 0; s_axi_arprot = 0;
    s_axi_arvalid = 0; s_axi_rready = 0;
    repeat (3) step();
    check("rst_gp_req", {write, read}, 2'b00);
    check("rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    check("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'b0000);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_wregs", {write_addrs, write_data, write_strobe}, 0);
    check("rst_raddr", read_addrs, 0);
    check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    rst = 0;
    step();

    // AW first, W three cycles later, done after 3 request cycles
    gp_wdelay = 3;
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, 2'b00, 3);
    ref_mem[8] = 32'hDEADBEEF;
    // W before AW
    gp_wdelay = 1;
    do_write(8'h04, 32'h12345678, 4'hF, 2, 0, 1, 2'b00, 1);
    ref_mem[4] = 32'h12345678;
    gp_rdelay = 2;
    do_read(8'h04, 4, 2'b00, 32'h12345678, 2);
    do_read(8'h40, 1, 2'b10, 32'h0, 0);
    do_write(8'h80, 32'hCAFEF00D, 4'hF, 0, 0, 1, 2'b10, 0);
    do_read(8'h08, 0, 2'b00, 32'hDEADBEEF, 2);

    // write error completing in the same cycle as a good read
    gp_wdelay = 2; gp_rdelay = 2; gp_werr = 1; gp_rerr = 0;
    s_axi_awaddr = 8'h10; s_axi_wdata = 32'h55AA55AA; s_axi_wstrb = 4'hF; s_axi_araddr = 8'h04;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    n = 0;
    while (s_axi_bvalid !== 1'b1 && s_axi_rvalid !== 1'b1 && n < 50) begin step(); n++; end
    check("conc_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    check("conc_bresp", s_axi_bresp, 2'b10);
    check("conc_rresp", s_axi_rresp, 2'b00);
    check("conc_rdata", s_axi_rdata, ref_mem[4]);
    s_axi_bready = 1; s_axi_rready = 1;
    step();
    s_axi_bready = 0; s_axi_rready = 0;
    check("conc_clear", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
    gp_werr = 0;

    // asynchronous reset while the GP write is pending
    gp_wdelay = 0;
    s_axi_awaddr = 8'h0C; s_axi_wdata = 32'h01020304; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    step();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    check("pre_rst_write", write, 1);
    step();
    rst = 1;
    #1;
    check("midrst_write", write, 0);
    check("midrst_bvalid", s_axi_bvalid, 0);
    check("midrst_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    step();
    rst = 0;
    step();
    gp_wdelay = 2;
    do_write(8'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 2'b00, 2);
    ref_mem[12] = 32'hA5A5A5A5;

    // randomized traffic against the register-file model
    for (int it = 0; it < 24; it++) begin
      a = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[7:6] = 2'($urandom_range(1, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      gp_wdelay = $urandom_range(1, 4);
      gp_werr = ($urandom_range(0, 4) == 0);
      oor = (a[7:6] != 2'b00);
      do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
               (oor || gp_werr) ? 2'b10 : 2'b00, oor ? 0 : gp_wdelay);
      if (!oor && !gp_werr) ref_mem[a[5:0]] = merge(ref_mem[a[5:0]], d, s);
      gp_werr = 0;
      if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) a[6] = 1'b1;
      oor = (a[7:6] != 2'b00);
      gp_rdelay = $urandom_range(1, 4);
      gp_rerr = ($urandom_range(0, 4) == 0);
      do_read(a, $urandom_range(0, 2), (oor || gp_rerr) ? 2'b10 : 2'b00,
              oor ? 32'h0 : ref_mem[a[5:0]], oor ? 0 : gp_rdelay);
      gp_rerr = 0;
    end

`ifdef AXIL_TIMEOUT_EN
    gp_wdelay = 0;
    do_write(8'h14, 32'h11112222, 4'hF, 0, 0, 0, 2'b10, TO);
    gp_wdelay = TO;
    do_write(8'h14, 32'h33334444, 4'hF, 0, 0, 0, 2'b00, TO);
    ref_mem[20] = 32'h33334444;
    gp_rdelay = 0;
    do_read(8'h14, 1, 2'b10, 32'h0, TO);
    gp_rdelay = TO;
    do_read(8'h14, 0, 2'b00, 32'h33334444, TO);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
